// File: rtl/fc2_argmax_reader.sv
// fc2_argmax_reader: latches the ten FC2 class scores and finds the argmax with one compare per cycle.
// Optional macro ARGMAX_NAN_SKIP_EN: NaN scores are excluded from the argmax.
module fc2_argmax_reader #(
  parameter int DATA_WIDTH        = 32,
  parameter int NUMBER_OF_CLASSES = 10,
  parameter int CLASS_BITS        = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] Data_in_1,
  input  logic [DATA_WIDTH-1:0] Data_in_2,
  input  logic [DATA_WIDTH-1:0] Data_in_3,
  input  logic [DATA_WIDTH-1:0] Data_in_4,
  input  logic [DATA_WIDTH-1:0] Data_in_5,
  input  logic [DATA_WIDTH-1:0] Data_in_6,
  input  logic [DATA_WIDTH-1:0] Data_in_7,
  input  logic [DATA_WIDTH-1:0] Data_in_8,
  input  logic [DATA_WIDTH-1:0] Data_in_9,
  input  logic [DATA_WIDTH-1:0] Data_in_10,
  input  logic                  Get_final_value,
  input  logic                  result_ack,
  input  logic [CLASS_BITS-1:0] rd_index,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [CLASS_BITS-1:0] class_id,
  output logic [DATA_WIDTH-1:0] max_value,
  output logic                  result_valid,
  output logic                  busy,
  output logic                  overflow_err
);

  if (DATA_WIDTH != 32 || NUMBER_OF_CLASSES != 10 || CLASS_BITS != 4) begin : g_param_check
    $error("fc2_argmax_reader: only DATA_WIDTH=32, NUMBER_OF_CLASSES=10, CLASS_BITS=4 are supported");
  end

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CLASS_BITS-1:0] LAST_IDX  = CLASS_BITS'(NUMBER_OF_CLASSES - 1);
  localparam logic [CLASS_BITS-1:0] NUM_IDX   = CLASS_BITS'(NUMBER_OF_CLASSES);

  // Strict a > b on binary32; +0 and -0 compare equal.
  function automatic logic fp_gt(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
    logic res;
    if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1])
      res = !a[DATA_WIDTH-1] && !((a[DATA_WIDTH-2:0] == '0) && (b[DATA_WIDTH-2:0] == '0));
    else if (!a[DATA_WIDTH-1])
      res = a[DATA_WIDTH-2:0] > b[DATA_WIDTH-2:0];
    else
      res = a[DATA_WIDTH-2:0] < b[DATA_WIDTH-2:0];
    return res;
  endfunction

`ifdef ARGMAX_NAN_SKIP_EN
  localparam logic [DATA_WIDTH-1:0] NAN_CANON = 32'h7FC00000;

  function automatic logic is_nan(input logic [DATA_WIDTH-1:0] a);
    return (a[30:23] == 8'hFF) && (a[22:0] != '0);
  endfunction

  logic best_ok_q, best_ok_d;
`endif

  logic [DATA_WIDTH-1:0] din      [NUMBER_OF_CLASSES];
  logic [DATA_WIDTH-1:0] scores_q [NUMBER_OF_CLASSES];
  logic [DATA_WIDTH-1:0] scores_d [NUMBER_OF_CLASSES];

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] best_val_q, best_val_d;
  logic [CLASS_BITS-1:0] best_idx_q, best_idx_d;
  logic [CLASS_BITS-1:0] idx_q, idx_d;
  logic [CLASS_BITS-1:0] class_id_q, class_id_d;
  logic [DATA_WIDTH-1:0] max_value_q, max_value_d;
  logic                  valid_q, valid_d;
  logic                  overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0] cand;
  logic                  take;
  logic                  capture;

  assign din[0] = Data_in_1;
  assign din[1] = Data_in_2;
  assign din[2] = Data_in_3;
  assign din[3] = Data_in_4;
  assign din[4] = Data_in_5;
  assign din[5] = Data_in_6;
  assign din[6] = Data_in_7;
  assign din[7] = Data_in_8;
  assign din[8] = Data_in_9;
  assign din[9] = Data_in_10;

  assign capture = Get_final_value && (state_q != S_SCAN);
  assign cand    = scores_q[idx_q];

`ifdef ARGMAX_NAN_SKIP_EN
  assign take = !is_nan(cand) && (!best_ok_q || fp_gt(cand, best_val_q));
`else
  assign take = fp_gt(cand, best_val_q);
`endif

  always_comb begin
    state_d     = state_q;
    scores_d    = scores_q;
    best_val_d  = best_val_q;
    best_idx_d  = best_idx_q;
    idx_d       = idx_q;
    class_id_d  = class_id_q;
    max_value_d = max_value_q;
    valid_d     = valid_q;
    overflow_d  = overflow_q;
`ifdef ARGMAX_NAN_SKIP_EN
    best_ok_d   = best_ok_q;
`endif

    case (state_q)
      S_IDLE: ;
      S_SCAN: begin
        if (Get_final_value) overflow_d = 1'b1;
        if (take) begin
          best_val_d = cand;
          best_idx_d = idx_q;
`ifdef ARGMAX_NAN_SKIP_EN
          best_ok_d  = 1'b1;
`endif
        end
        // The result registers take the post-compare best of the last index.
        if (idx_q == LAST_IDX) begin
          state_d     = S_DONE;
          valid_d     = 1'b1;
          class_id_d  = best_idx_d;
          max_value_d = best_val_d;
`ifdef ARGMAX_NAN_SKIP_EN
          if (!best_ok_d) begin
            class_id_d  = '1;
            max_value_d = NAN_CANON;
          end
`endif
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        if (result_ack) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A new strobe outside SCAN always starts a capture, even alongside an ack.
    if (capture) begin
      scores_d   = din;
      best_val_d = din[0];
      best_idx_d = '0;
      idx_d      = CLASS_BITS'(1);
      valid_d    = 1'b0;
      state_d    = S_SCAN;
`ifdef ARGMAX_NAN_SKIP_EN
      best_ok_d  = !is_nan(din[0]);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      scores_q    <= '{default: '0};
      best_val_q  <= '0;
      best_idx_q  <= '0;
      idx_q       <= '0;
      class_id_q  <= '0;
      max_value_q <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
`ifdef ARGMAX_NAN_SKIP_EN
      best_ok_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      scores_q    <= scores_d;
      best_val_q  <= best_val_d;
      best_idx_q  <= best_idx_d;
      idx_q       <= idx_d;
      class_id_q  <= class_id_d;
      max_value_q <= max_value_d;
      valid_q     <= valid_d;
      overflow_q  <= overflow_d;
`ifdef ARGMAX_NAN_SKIP_EN
      best_ok_q   <= best_ok_d;
`endif
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_index < NUM_IDX) rd_data = scores_q[rd_index];
  end

  assign class_id     = class_id_q;
  assign max_value    = max_value_q;
  assign result_valid = valid_q;
  assign busy         = (state_q == S_SCAN);
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_fc2_argmax_reader.sv
// Directed bench for fc2_argmax_reader: latency, tie/sign rules, overflow, re-capture, reset abort, NaN handling.
module tb_fc2_argmax_reader;

  logic        clk;
  logic        reset;
  logic [31:0] sc [10];
  logic        Get_final_value;
  logic        result_ack;
  logic [3:0]  rd_index;
  logic [31:0] rd_data;
  logic [3:0]  class_id;
  logic [31:0] max_value;
  logic        result_valid;
  logic        busy;
  logic        overflow_err;

  int unsigned n_cmp;
  int unsigned n_err;

  fc2_argmax_reader #(
    .DATA_WIDTH(32),
    .NUMBER_OF_CLASSES(10),
    .CLASS_BITS(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .Data_in_1(sc[0]),
    .Data_in_2(sc[1]),
    .Data_in_3(sc[2]),
    .Data_in_4(sc[3]),
    .Data_in_5(sc[4]),
    .Data_in_6(sc[5]),
    .Data_in_7(sc[6]),
    .Data_in_8(sc[7]),
    .Data_in_9(sc[8]),
    .Data_in_10(sc[9]),
    .Get_final_value(Get_final_value),
    .result_ack(result_ack),
    .rd_index(rd_index),
    .rd_data(rd_data),
    .class_id(class_id),
    .max_value(max_value),
    .result_valid(result_valid),
    .busy(busy),
    .overflow_err(overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [31:0] v);
    for (int i = 0; i < 10; i++) sc[i] = v;
  endtask

  // Strobe sampled at the next edge (edge N); returns 1 time unit after it.
  task automatic strobe(input logic with_ack);
    Get_final_value = 1'b1;
    result_ack      = with_ack;
    step(1);
    Get_final_value = 1'b0;
    result_ack      = 1'b0;
  endtask

  task automatic do_ack();
    result_ack = 1'b1;
    step(1);
    result_ack = 1'b0;
  endtask

  // Called just after edge N: valid must stay low through N+8 and rise at N+9.
  task automatic run_to_done(input string tag, input logic [3:0] cls, input logic [31:0] mx);
    step(8);
    check_eq({tag, ".valid_n8"}, 32'(result_valid), 32'd0);
    check_eq({tag, ".busy_n8"}, 32'(busy), 32'd1);
    step(1);
    check_eq({tag, ".valid_n9"}, 32'(result_valid), 32'd1);
    check_eq({tag, ".busy_n9"}, 32'(busy), 32'd0);
    check_eq({tag, ".class"}, 32'(class_id), 32'(cls));
    check_eq({tag, ".max"}, max_value, mx);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    Get_final_value = 1'b0;
    result_ack = 1'b0;
    rd_index = 4'd0;
    fill(32'h0);
    step(2);
    check_eq("rst.busy", 32'(busy), 32'd0);
    check_eq("rst.valid", 32'(result_valid), 32'd0);
    check_eq("rst.class", 32'(class_id), 32'd0);
    check_eq("rst.max", max_value, 32'd0);
    check_eq("rst.ovf", 32'(overflow_err), 32'd0);
    reset = 1'b0;
    step(1);

    // T1: 1.0 .. 10.0 ascending
    sc = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
           32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000, 32'h41200000};
    strobe(1'b0);
    check_eq("t1.busy_n", 32'(busy), 32'd1);
    check_eq("t1.valid_n", 32'(result_valid), 32'd0);
    run_to_done("t1", 4'd9, 32'h41200000);
    rd_index = 4'd3;  #1; check_eq("t1.rd3", rd_data, 32'h40800000);
    rd_index = 4'd9;  #1; check_eq("t1.rd9", rd_data, 32'h41200000);
    rd_index = 4'd10; #1; check_eq("t1.rd10", rd_data, 32'h0);
    rd_index = 4'd12; #1; check_eq("t1.rd12", rd_data, 32'h0);
    do_ack();
    check_eq("t1.ack_valid", 32'(result_valid), 32'd0);
    check_eq("t1.hold_class", 32'(class_id), 32'd9);

    // T2: all-equal tie, negative scores, +0/-0 tie
    fill(32'h40000000);
    strobe(1'b0);
    run_to_done("t2a", 4'd0, 32'h40000000);
    do_ack();
    fill(32'hC0A00000); sc[4] = 32'hC0400000;
    strobe(1'b0);
    run_to_done("t2b", 4'd4, 32'hC0400000);
    do_ack();
    fill(32'hBF800000); sc[0] = 32'h80000000; sc[5] = 32'h00000000;
    strobe(1'b0);
    run_to_done("t2z", 4'd0, 32'h80000000);
    do_ack();

    // T3: second strobe at N+4 is ignored and flags overflow
    fill(32'h3F800000); sc[2] = 32'h41100000;
    strobe(1'b0);
    step(3);
    fill(32'h3F800000); sc[7] = 32'h41200000;
    strobe(1'b0);
    check_eq("t3.busy_n4", 32'(busy), 32'd1);
    check_eq("t3.ovf", 32'(overflow_err), 32'd1);
    step(4);
    check_eq("t3.valid_n8", 32'(result_valid), 32'd0);
    step(1);
    check_eq("t3.valid_n9", 32'(result_valid), 32'd1);
    check_eq("t3.class", 32'(class_id), 32'd2);
    check_eq("t3.max", max_value, 32'h41100000);
    rd_index = 4'd7; #1; check_eq("t3.rd7_latched", rd_data, 32'h3F800000);
    do_ack();
    check_eq("t3.ovf_sticky", 32'(overflow_err), 32'd1);

    // T5: reset sampled at N+5 aborts the scan
    sc = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
           32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000, 32'h41200000};
    strobe(1'b0);
    step(4);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check_eq("t5.busy", 32'(busy), 32'd0);
    check_eq("t5.valid", 32'(result_valid), 32'd0);
    check_eq("t5.class", 32'(class_id), 32'd0);
    check_eq("t5.ovf", 32'(overflow_err), 32'd0);
    rd_index = 4'd12; #1; check_eq("t5.rd12", rd_data, 32'h0);
    step(4);
    check_eq("t5.valid_n9", 32'(result_valid), 32'd0);
    check_eq("t5.busy_n9", 32'(busy), 32'd0);

    // T4: re-capture from DONE without ack, then with a simultaneous ack
    fill(32'h3F800000); sc[5] = 32'h40A00000;
    strobe(1'b0);
    run_to_done("t4a", 4'd5, 32'h40A00000);
    fill(32'hBF800000); sc[1] = 32'h40000000;
    strobe(1'b0);
    check_eq("t4b.valid_drop", 32'(result_valid), 32'd0);
    check_eq("t4b.busy", 32'(busy), 32'd1);
    check_eq("t4b.ovf", 32'(overflow_err), 32'd0);
    check_eq("t4b.hold_class", 32'(class_id), 32'd5);
    run_to_done("t4b", 4'd1, 32'h40000000);
    fill(32'h3F800000); sc[8] = 32'h40400000;
    strobe(1'b1);
    check_eq("t4c.valid_drop", 32'(result_valid), 32'd0);
    check_eq("t4c.busy", 32'(busy), 32'd1);
    run_to_done("t4c", 4'd8, 32'h40400000);
    do_ack();
    check_eq("t4c.ack_valid", 32'(result_valid), 32'd0);
    do_ack();
    check_eq("t4.idle_ack_valid", 32'(result_valid), 32'd0);
    check_eq("t4.idle_ack_busy", 32'(busy), 32'd0);
    check_eq("t4.idle_ack_class", 32'(class_id), 32'd8);
    check_eq("t4.idle_ack_ovf", 32'(overflow_err), 32'd0);

    // T6: NaN scores
    fill(32'hBF800000); sc[0] = 32'h7FC00000; sc[3] = 32'h3FC00000;
    strobe(1'b0);
`ifdef ARGMAX_NAN_SKIP_EN
    run_to_done("t6a", 4'd3, 32'h3FC00000);
`else
    run_to_done("t6a", 4'd0, 32'h7FC00000);
`endif
    do_ack();
    fill(32'h7FC00000); sc[0] = 32'hFFC00000; sc[1] = 32'h7FC00001;
    strobe(1'b0);
`ifdef ARGMAX_NAN_SKIP_EN
    run_to_done("t6b", 4'hF, 32'h7FC00000);
`else
    run_to_done("t6b", 4'd1, 32'h7FC00001);
`endif
    do_ack();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
